// File: rtl/result_bcd_converter.sv
// result_bcd_converter
//   Sequential double-dabble converter: turns the calculator's unsigned binary
//   result into BCD digits for the 7-segment multiplexer, one bit per clock.
//   Inputs above MAX_VAL saturate to all nines and raise overflow.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   start     conversion request, sampled only when idle
//   binIn     unsigned binary value, captured on the edge that accepts start
//   busy      high while shifting
//   done      one-cycle pulse when digits/overflow have just been updated
//   digit3..0 BCD thousands..units, held between conversions
//   overflow  last captured value exceeded MAX_VAL (digits forced to 9)
module result_bcd_converter #(
    parameter int unsigned WIDTH   = 14,
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] binIn,
    output logic             busy,
    output logic             done,
    output logic [3:0]       digit3,
    output logic [3:0]       digit2,
    output logic [3:0]       digit1,
    output logic [3:0]       digit0,
    output logic             overflow
);

    localparam int unsigned SW = WIDTH + 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [WIDTH-1:0] MAX_BIN   = WIDTH'(MAX_VAL);
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);

    logic [1:0]          state_q, state_d;
    logic [SW-1:0]       scratch_q, scratch_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_pending_q, ovf_pending_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                overflow_q, overflow_d;

    logic [SW-1:0]       adjusted;
    logic [SW-1:0]       shifted;

    // Add-3 correction on every BCD nibble; each nibble wraps on its own so
    // nothing carries into its neighbour.
    always_comb begin
        adjusted = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[WIDTH + 4*i +: 4] >= 4'd5) begin
                adjusted[WIDTH + 4*i +: 4] = scratch_q[WIDTH + 4*i +: 4] + 4'd3;
            end
        end
        shifted = {adjusted[SW-2:0], 1'b0};
    end

    always_comb begin
        state_d       = state_q;
        scratch_d     = scratch_q;
        cnt_d         = cnt_q;
        ovf_pending_d = ovf_pending_q;
        bcd_d         = bcd_q;
        overflow_d    = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    scratch_d     = {{(4*DIGITS){1'b0}}, binIn};
                    cnt_d         = '0;
                    ovf_pending_d = (binIn > MAX_BIN);
                    state_d       = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    // Digits come from the post-step BCD field, not scratch_q.
                    bcd_d      = ovf_pending_q ? {DIGITS{4'd9}} : shifted[SW-1:WIDTH];
                    overflow_d = ovf_pending_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            scratch_q     <= '0;
            cnt_q         <= '0;
            ovf_pending_q <= 1'b0;
            bcd_q         <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            scratch_q     <= scratch_d;
            cnt_q         <= cnt_d;
            ovf_pending_q <= ovf_pending_d;
            bcd_q         <= bcd_d;
            overflow_q    <= overflow_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign digit3   = bcd_q[15:12];
    assign digit2   = bcd_q[11:8];
    assign digit1   = bcd_q[7:4];
    assign digit0   = bcd_q[3:0];
    assign overflow = overflow_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed testbench for result_bcd_converter. Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_result_bcd_converter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] binIn;
    logic        busy;
    logic        done;
    logic [3:0]  digit3, digit2, digit1, digit0;
    logic        overflow;
    logic [15:0] dig;

    int total;
    int bad;

    assign dig = {digit3, digit2, digit1, digit0};

    result_bcd_converter #(
        .WIDTH  (14),
        .DIGITS (4),
        .MAX_VAL(9999)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .binIn   (binIn),
        .busy    (busy),
        .done    (done),
        .digit3  (digit3),
        .digit2  (digit2),
        .digit1  (digit1),
        .digit0  (digit0),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present start for one rising edge; returns half a cycle after acceptance.
    task automatic do_start(input logic [13:0] v);
        @(negedge clk);
        binIn = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done; counts falling edges and busy samples on the way.
    task automatic wait_done(output int cyc, output int busy_n, output int both);
        cyc    = 0;
        busy_n = 0;
        both   = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            cyc++;
        end
        if (busy === 1'b1 && done === 1'b1) both = 1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        binIn = '0;
        #12;
        total++;
        if ({busy, done, overflow, dig} !== 19'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b dig=%h, want all 0",
                     busy, done, overflow, dig);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_zero();
        int cyc, bn, both;
        do_start(14'd0);
        wait_done(cyc, bn, both);
        total++;
        if (cyc !== 14) begin
            bad++;
            $display("FAIL zero_latency: got %0d, want 14", cyc);
        end
        total++;
        if (bn !== 14) begin
            bad++;
            $display("FAIL zero_busy_cycles: got %0d, want 14", bn);
        end
        total++;
        if (both !== 0) begin
            bad++;
            $display("FAIL zero_busy_done_overlap: got %0d, want 0", both);
        end
        total++;
        if ({overflow, dig} !== 17'h0_0000) begin
            bad++;
            $display("FAIL zero_result: got ovf=%b dig=%h, want ovf=0 dig=0000", overflow, dig);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL zero_done_pulse_width: got done=%b, want 0", done);
        end
    endtask

    task automatic test_values();
        logic [13:0] vin  [6] = '{14'd1234, 14'd9999, 14'd1000, 14'd10000, 14'd16383, 14'd42};
        logic [15:0] vexp [6] = '{16'h1234, 16'h9999, 16'h1000, 16'h9999, 16'h9999, 16'h0042};
        logic        vovf [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int cyc, bn, both;
        for (int i = 0; i < 6; i++) begin
            do_start(vin[i]);
            wait_done(cyc, bn, both);
            total++;
            if (cyc !== 14) begin
                bad++;
                $display("FAIL value_latency[%0d]: got %0d, want 14", vin[i], cyc);
            end
            total++;
            if (dig !== vexp[i] || overflow !== vovf[i]) begin
                bad++;
                $display("FAIL value_result[%0d]: got dig=%h ovf=%b, want dig=%h ovf=%b",
                         vin[i], dig, overflow, vexp[i], vovf[i]);
            end
        end
        // Outputs must hold between conversions.
        repeat (3) @(negedge clk);
        total++;
        if (dig !== 16'h0042 || overflow !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL hold_idle: got dig=%h ovf=%b busy=%b, want 0042 0 0",
                     dig, overflow, busy);
        end
    endtask

    task automatic test_ignored_start();
        int cyc, bn, both;
        do_start(14'd5678);
        repeat (3) @(negedge clk);
        binIn = 14'd77;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bn, both);
        total++;
        if (cyc !== 10) begin
            bad++;
            $display("FAIL ignore_shift_latency: got %0d, want 10", cyc);
        end
        total++;
        if (dig !== 16'h5678 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL ignore_shift_result: got dig=%h ovf=%b, want 5678 0", dig, overflow);
        end
        // Start during DONE is ignored, then held into IDLE where it is accepted.
        binIn = 14'd77;
        start = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL ignore_done_start: got busy=%b done=%b, want 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL back_to_back_accept: got busy=%b, want 1", busy);
        end
        wait_done(cyc, bn, both);
        total++;
        if (cyc !== 14 || dig !== 16'h0077) begin
            bad++;
            $display("FAIL back_to_back_result: got cyc=%0d dig=%h, want 14 0077", cyc, dig);
        end
    endtask

    task automatic test_bin_change();
        int cyc, bn, both;
        @(negedge clk);
        binIn = 14'd321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        binIn = 14'd999;
        wait_done(cyc, bn, both);
        total++;
        if (dig !== 16'h0321 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL bin_change: got dig=%h ovf=%b, want 0321 0", dig, overflow);
        end
    endtask

    task automatic test_reset_midway();
        int cyc, bn, both;
        int seen_done;
        do_start(14'd1111);
        wait_done(cyc, bn, both);
        total++;
        if (dig !== 16'h1111) begin
            bad++;
            $display("FAIL pre_reset_result: got %h, want 1111", dig);
        end
        do_start(14'd4321);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({busy, done, overflow, dig} !== 19'd0) begin
            bad++;
            $display("FAIL midway_reset_outputs: got busy=%b done=%b ovf=%b dig=%h, want all 0",
                     busy, done, overflow, dig);
        end
        @(negedge clk);
        rst = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        total++;
        if (seen_done !== 0) begin
            bad++;
            $display("FAIL no_done_after_reset: got %0d active cycles, want 0", seen_done);
        end
        do_start(14'd4321);
        wait_done(cyc, bn, both);
        total++;
        if (cyc !== 14 || dig !== 16'h4321 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL fresh_after_reset: got cyc=%0d dig=%h ovf=%b, want 14 4321 0",
                     cyc, dig, overflow);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_zero();
        test_values();
        test_ignored_start();
        test_bin_change();
        test_reset_midway();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_bcd_converter.md
Name: result_bcd_converter

Overview:
- Converts the calculator's 14-bit unsigned binary result into four BCD digits for the display path.
- Sits directly downstream of the arithmetic unit and upstream of the 7-segment multiplexer.
- Sequential shift-add-3 (double dabble) conversion: one bit per clock, start/busy/done handshake.
- Values above the displayable range saturate to 9999 and raise an overflow flag.

Parameters:
WIDTH, 14, binary input width; also the number of shift steps per conversion.
DIGITS, 4, number of BCD output digits; scratch register is WIDTH+4*DIGITS bits.
MAX_VAL, 9999, largest displayable value; larger inputs saturate.

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request a conversion; sampled only in IDLE
binIn  input  WIDTH  unsigned binary value; captured on the edge that accepts start
busy  output  1  high while a conversion is in progress (SHIFT state)
done  output  1  one-cycle pulse: digits/overflow have just been updated
digit3  output  4  BCD thousands
digit2  output  4  BCD hundreds
digit1  output  4  BCD tens
digit0  output  4  BCD units
overflow  output  1  captured binIn exceeded MAX_VAL; digits forced to 9

Behaviour:
- Reset (rst low, any time, asynchronous): state=IDLE, busy=0, done=0, overflow=0, digit3..digit0=0, step counter=0, scratch=0. A conversion in flight is abandoned; no done pulse follows reset release.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on an edge with start=1:
  - load scratch = {4*DIGITS zeros, binIn};
  - counter = 0;
  - latch ovf_pending = (binIn > MAX_VAL);
  - go to SHIFT.
  - start=0: stay in IDLE, outputs hold.
- SHIFT, one step per edge:
  - every BCD nibble >= 5 gets +3, computed combinationally;
  - then the whole scratch shifts left by 1;
  - counter increments.
- Final step (counter = WIDTH-1):
  - the step executes;
  - digit outputs load from the post-step BCD field;
  - overflow loads ovf_pending; if set, all digits load 9 instead;
  - go to DONE.
- DONE: done=1 for exactly this one cycle, then unconditionally go to IDLE.
- busy=1 exactly while in SHIFT; done=1 exactly while in DONE; busy and done never high together.
- Latency: start accepted at edge k; done high during cycle [k+WIDTH, k+WIDTH+1). For WIDTH=14 that is 14 cycles.
- Start is ignored in SHIFT and DONE. Minimum start-to-start interval is WIDTH+2 edges. binIn changes after the accepting edge have no effect.
- Digit outputs and overflow hold their last values between conversions; they change only on the final SHIFT edge or on reset.
- Arithmetic:
  - binIn is unsigned;
  - a wrapped subtraction result (e.g. 0-1 = 16383) is treated as 16383 and therefore overflows;
  - the add-3 correction never carries between nibbles.
- Valid outputs never contain nibble values above 9.

Test Plan:
- Reset then start with binIn=0 -> busy high 14 cycles, done pulse at k+14, digits 0,0,0,0, overflow=0.
- binIn=1234 -> digits 1,2,3,4, overflow=0. binIn=9999 -> 9,9,9,9, overflow=0. binIn=1000 -> 1,0,0,0.
- binIn=10000 and binIn=16383 -> digits 9,9,9,9, overflow=1. A following conversion of 42 -> 0,0,4,2 with overflow cleared to 0.
- Pulse start (binIn=77) while converting 5678, and again during the DONE cycle -> both ignored; result 5,6,7,8; exactly one done pulse. A start issued one cycle after done is accepted.
- Change binIn from 321 to 999 one cycle after start is accepted -> result 0,3,2,1.
- Assert rst at step 7 of converting 4321 (digits previously 1,1,1,1) -> outputs immediately 0, busy=0, no done after release. A fresh conversion of 4321 -> 4,3,2,1.
